// File: rtl/downscale_controller_if.sv
// Handshake bundle for downscale_controller.
// Upstream sample stream in, downstream difference stream out.
interface downscale_controller_if #(
    parameter int DATA_SIZE = 16
);
    logic                 start_i;
    logic                 in_valid_i;
    logic [DATA_SIZE-1:0] in_data_i;
    logic                 in_ready_o;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [DATA_SIZE:0]   sub_result_o;
    logic                 out_last_o;
    logic [DATA_SIZE-1:0] max_o;
    logic                 busy_o;
    logic                 done_o;

    modport master (
        output start_i, in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, sub_result_o,
        input  out_last_o, max_o, busy_o, done_o
    );

    modport slave (
        input  start_i, in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, sub_result_o,
        output out_last_o, max_o, busy_o, done_o
    );
endinterface

// File: rtl/downscale_controller.sv
// Softmax downscale sequencer: load a frame, track max, emit sample - max.
// Optional macro DOWNSCALE_CTRL_CLAMP_EN saturates result to DATA_SIZE signed.
module downscale_controller #(
    parameter int DATA_SIZE      = 16,
    parameter int NUMBER_OF_DATA = 10
) (
    input logic                  clock_i,
    input logic                  reset_i,
    downscale_controller_if.slave bus
);
    localparam int IW = $clog2(NUMBER_OF_DATA);
    localparam logic [IW-1:0] LAST = IW'(NUMBER_OF_DATA - 1);
    localparam logic signed [DATA_SIZE-1:0] MOST_NEG =
        {1'b1, {(DATA_SIZE-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EMIT,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [IW-1:0]               wr_idx;
    logic [IW-1:0]               rd_idx;
    logic signed [DATA_SIZE-1:0] max_reg;
    logic signed [DATA_SIZE-1:0] data_buf [NUMBER_OF_DATA];
    logic                        in_fire;
    logic                        out_fire;
    logic signed [DATA_SIZE:0]   diff;
    logic signed [DATA_SIZE:0]   result;

    assign in_fire  = (state == LOAD) && bus.in_valid_i;
    assign out_fire = (state == EMIT) && bus.out_ready_i;

    // Widen both operands by one sign bit so the difference cannot overflow
    assign diff = {data_buf[rd_idx][DATA_SIZE-1], data_buf[rd_idx]}
                - {max_reg[DATA_SIZE-1], max_reg};

`ifdef DOWNSCALE_CTRL_CLAMP_EN
    localparam logic signed [DATA_SIZE:0] FLOOR =
        {2'b11, {(DATA_SIZE-1){1'b0}}};
    assign result = (diff < FLOOR) ? FLOOR : diff;
`else
    assign result = diff;
`endif

    assign bus.max_o = max_reg;

    // State register; reset dominates any pending start
    always_ff @(posedge clock_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_nxt        = state;
        bus.in_ready_o   = 1'b0;
        bus.out_valid_o  = 1'b0;
        bus.out_last_o   = 1'b0;
        bus.sub_result_o = '0;
        bus.busy_o       = 1'b0;
        bus.done_o       = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start_i) state_nxt = LOAD;
            end
            LOAD: begin
                bus.in_ready_o = 1'b1;
                bus.busy_o     = 1'b1;
                if (in_fire && wr_idx == LAST) state_nxt = EMIT;
            end
            EMIT: begin
                bus.out_valid_o  = 1'b1;
                bus.busy_o       = 1'b1;
                bus.out_last_o   = (rd_idx == LAST);
                bus.sub_result_o = result;
                if (out_fire && rd_idx == LAST) state_nxt = DONE;
            end
            DONE: begin
                bus.done_o = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Indices and running maximum; strict compare keeps the first peak
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_idx  <= '0;
            rd_idx  <= '0;
            max_reg <= MOST_NEG;
        end else begin
            if (state == IDLE && bus.start_i) begin
                wr_idx  <= '0;
                rd_idx  <= '0;
                max_reg <= MOST_NEG;
            end
            if (in_fire) begin
                if ($signed(bus.in_data_i) > max_reg)
                    max_reg <= $signed(bus.in_data_i);
                if (wr_idx != LAST) wr_idx <= wr_idx + 1'b1;
                else                rd_idx <= '0;
            end
            if (out_fire && rd_idx != LAST)
                rd_idx <= rd_idx + 1'b1;
        end
    end

    // Sample buffer; contents are don't-care until written
    always_ff @(posedge clock_i) begin
        if (in_fire) data_buf[wr_idx] <= bus.in_data_i;
    end
endmodule

// File: tb/tb_downscale_controller.sv
// Bench for downscale_controller: scenario tasks against a
// frame-level reference model (max of frame, sample minus max).
module tb_downscale_controller;
    localparam int DS = 16;
    localparam int N  = 10;
    typedef logic [DS:0]   res_t;
    typedef logic [DS-1:0] smp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    downscale_controller_if #(.DATA_SIZE(DS)) bus ();

    downscale_controller #(
        .DATA_SIZE(DS),
        .NUMBER_OF_DATA(N)
    ) dut (
        .clock_i(clk),
        .reset_i(rst),
        .bus(bus)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    smp_t samp    [N];
    res_t got_res [N];
    logic got_last[N];
    res_t exp_res [N];
    res_t ref_res [N];
    smp_t exp_max;
    smp_t got_max;
    int   n_hs, done_cyc, first_lat, unstable, done_after;
    bit   timeout;

    // Frame-level model: max over samples, then each sample minus max
    function automatic void model();
        int m;
        int d;
        m = int'($signed(samp[0]));
        for (int i = 1; i < N; i++)
            if (int'($signed(samp[i])) > m) m = int'($signed(samp[i]));
        exp_max = smp_t'(m);
        for (int i = 0; i < N; i++) begin
            d = int'($signed(samp[i])) - m;
`ifdef DOWNSCALE_CTRL_CLAMP_EN
            if (d < -(1 << (DS - 1))) d = -(1 << (DS - 1));
`endif
            exp_res[i] = res_t'(d);
        end
    endfunction

    // Drives one frame and records what came out.
    // ready_mode: 0 always, 1 pattern 1,0,0, 2 random
    task automatic run_frame(input int ready_mode, input int gap_at,
                             input bit rand_valid, input bit glitch);
        int   wr = 0;
        int   rd = 0;
        int   cyc;
        int   k = 0;
        int   gap_left = 0;
        bit   gap_used = 0;
        bit   stalled = 0;
        bit   seen_valid = 0;
        int   last_in = 0;
        res_t hold_res = '0;
        logic hold_last = 1'b0;
        n_hs = 0; done_cyc = 0; first_lat = -1;
        unstable = 0; done_after = 0; timeout = 0;
        got_max = '0;
        for (int i = 0; i < N; i++) begin
            got_res[i] = '0;
            got_last[i] = 1'b0;
        end
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        cyc = 2;
        while (1) begin
            if (cyc > 400) begin
                timeout = 1;
                break;
            end
            if (gap_at >= 0 && wr == gap_at && !gap_used) begin
                gap_left = 3;
                gap_used = 1;
            end
            bus.in_valid_i = (wr < N) && (gap_left == 0)
                && (!rand_valid || $urandom_range(0, 3) != 0);
            if (gap_left > 0) gap_left--;
            bus.in_data_i = (wr < N) ? samp[wr] : smp_t'($urandom);
            case (ready_mode)
                0:       bus.out_ready_i = 1'b1;
                1:       bus.out_ready_i = (k % 3 == 0);
                default: bus.out_ready_i = 1'($urandom_range(0, 1));
            endcase
            bus.start_i = glitch && (cyc == 4
                || (bus.out_valid_o && rd == 0) || bus.done_o);
            if (bus.done_o) begin
                done_cyc = cyc;
                got_max = bus.max_o;
                @(posedge clk); #1;
                bus.start_i = 1'b0;
                done_after = bus.done_o + bus.busy_o;
                @(posedge clk); #1;
                done_after += bus.busy_o;
                break;
            end
            if (bus.in_valid_i && bus.in_ready_o) begin
                wr++;
                last_in = cyc;
            end
            if (bus.out_valid_o) begin
                if (!seen_valid) first_lat = cyc - last_in;
                seen_valid = 1;
                if (stalled && (bus.sub_result_o !== hold_res
                    || bus.out_last_o !== hold_last))
                    unstable++;
                if (bus.out_ready_i) begin
                    if (rd < N) begin
                        got_res[rd] = bus.sub_result_o;
                        got_last[rd] = bus.out_last_o;
                    end
                    rd++;
                    n_hs++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    hold_res = bus.sub_result_o;
                    hold_last = bus.out_last_o;
                end
                k++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid_i = 1'b0;
        bus.out_ready_i = 1'b0;
        bus.start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start_i = 1'b1;
        bus.in_valid_i = 1'b1;
        bus.in_data_i = 16'h7FFF;
        bus.out_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.start_i = 1'b0;
        n_cmp++;
        if ({bus.in_ready_o, bus.out_valid_o, bus.out_last_o,
             bus.busy_o, bus.done_o} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags got=%b want=00000",
                {bus.in_ready_o, bus.out_valid_o, bus.out_last_o,
                 bus.busy_o, bus.done_o});
        end
        n_cmp++;
        if (bus.sub_result_o !== 17'h0) begin
            n_bad++;
            $display("FAIL reset_sub got=%h want=0", bus.sub_result_o);
        end
        n_cmp++;
        if (bus.max_o !== 16'h8000) begin
            n_bad++;
            $display("FAIL reset_max got=%h want=8000", bus.max_o);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.in_ready_o, bus.busy_o} !== 2'b0) begin
            n_bad++;
            $display("FAIL idle_ignores_valid got=%b want=00",
                {bus.in_ready_o, bus.busy_o});
        end
        bus.in_valid_i = 1'b0;
        bus.out_ready_i = 1'b0;
    endtask

    task automatic test_alternating();
        for (int i = 0; i < N; i++)
            samp[i] = (i % 2 == 0) ? 16'hA440 : 16'h2120;
        model();
        run_frame(0, -1, 0, 0);
        n_cmp++;
        if (timeout || got_max !== 16'h2120) begin
            n_bad++;
            $display("FAIL alt_max got=%h want=2120 to=%0d", got_max, timeout);
        end
        n_cmp++;
        if (got_res[0] !== 17'h18320 || got_res[1] !== 17'h0) begin
            n_bad++;
            $display("FAIL alt_pair got=%h,%h want=18320,00000",
                got_res[0], got_res[1]);
        end
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (got_res[i] !== exp_res[i]
                || got_last[i] !== (i == N - 1)) begin
                n_bad++;
                $display("FAIL alt_out[%0d] got=%h/%b want=%h/%b", i,
                    got_res[i], got_last[i], exp_res[i], i == N - 1);
            end
        end
        n_cmp++;
        if (done_cyc !== 2 * N + 2) begin
            n_bad++;
            $display("FAIL alt_done_cycle got=%0d want=%0d",
                done_cyc, 2 * N + 2);
        end
        n_cmp++;
        if (first_lat !== 1) begin
            n_bad++;
            $display("FAIL alt_first_valid got=%0d want=1", first_lat);
        end
        n_cmp++;
        if (done_after !== 0) begin
            n_bad++;
            $display("FAIL alt_done_pulse got=%0d want=0", done_after);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < N; i++)
            samp[i] = (i % 2 == 0) ? 16'hA440 : 16'h2120;
        model();
        run_frame(1, -1, 0, 0);
        n_cmp++;
        if (timeout || n_hs !== N) begin
            n_bad++;
            $display("FAIL bp_handshakes got=%0d want=%0d", n_hs, N);
        end
        n_cmp++;
        if (unstable !== 0) begin
            n_bad++;
            $display("FAIL bp_stable got=%0d want=0", unstable);
        end
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (got_res[i] !== exp_res[i]
                || got_last[i] !== (i == N - 1)) begin
                n_bad++;
                $display("FAIL bp_out[%0d] got=%h/%b want=%h/%b", i,
                    got_res[i], got_last[i], exp_res[i], i == N - 1);
            end
        end
    endtask

    task automatic test_full_range();
        res_t want3;
        for (int i = 0; i < N; i++)
            samp[i] = (i == 3) ? 16'h8000 : 16'h7FFF;
`ifdef DOWNSCALE_CTRL_CLAMP_EN
        want3 = 17'h18000;
`else
        want3 = 17'h10001;
`endif
        run_frame(0, -1, 0, 0);
        n_cmp++;
        if (timeout || got_max !== 16'h7FFF) begin
            n_bad++;
            $display("FAIL fr_max got=%h want=7fff", got_max);
        end
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (got_res[i] !== ((i == 3) ? want3 : 17'h0)) begin
                n_bad++;
                $display("FAIL fr_out[%0d] got=%h want=%h", i,
                    got_res[i], (i == 3) ? want3 : 17'h0);
            end
        end
    endtask

    task automatic test_gaps_and_start();
        for (int i = 0; i < N; i++) samp[i] = smp_t'($urandom);
        samp[7] = samp[2];
        model();
        run_frame(0, -1, 0, 0);
        for (int i = 0; i < N; i++) ref_res[i] = got_res[i];
        run_frame(0, 5, 0, 1);
        n_cmp++;
        if (timeout || done_cyc !== 2 * N + 2 + 3) begin
            n_bad++;
            $display("FAIL gap_done_cycle got=%0d want=%0d",
                done_cyc, 2 * N + 5);
        end
        n_cmp++;
        if (done_after !== 0) begin
            n_bad++;
            $display("FAIL gap_start_in_done got=%0d want=0", done_after);
        end
        n_cmp++;
        if (got_max !== exp_max) begin
            n_bad++;
            $display("FAIL gap_max got=%h want=%h", got_max, exp_max);
        end
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (got_res[i] !== exp_res[i] || ref_res[i] !== exp_res[i]) begin
                n_bad++;
                $display("FAIL gap_out[%0d] got=%h nogap=%h want=%h", i,
                    got_res[i], ref_res[i], exp_res[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int seen = 0;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        bus.in_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_data_i = smp_t'($urandom);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid_i = 1'b0;
        n_cmp++;
        if ({bus.in_ready_o, bus.out_valid_o, bus.out_last_o,
             bus.busy_o, bus.done_o} !== 5'b0
            || bus.sub_result_o !== 17'h0) begin
            n_bad++;
            $display("FAIL midrst_idle got=%b/%h want=00000/0",
                {bus.in_ready_o, bus.out_valid_o, bus.out_last_o,
                 bus.busy_o, bus.done_o}, bus.sub_result_o);
        end
        repeat (25) begin
            seen += bus.done_o + bus.busy_o;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL midrst_no_done got=%0d want=0", seen);
        end
        for (int i = 0; i < N; i++) samp[i] = 16'h0100;
        run_frame(0, -1, 0, 0);
        n_cmp++;
        if (timeout || got_max !== 16'h0100) begin
            n_bad++;
            $display("FAIL midrst_max got=%h want=0100", got_max);
        end
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (got_res[i] !== 17'h0) begin
                n_bad++;
                $display("FAIL midrst_out[%0d] got=%h want=0", i, got_res[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < N; i++)
                samp[i] = $urandom_range(0, 2) == 0
                    ? smp_t'($urandom_range(0, 3) * 16'h4000)
                    : smp_t'($urandom);
            model();
            run_frame(2, -1, 1, f[0]);
            n_cmp++;
            if (timeout || n_hs !== N || unstable !== 0
                || done_after !== 0) begin
                n_bad++;
                $display("FAIL rnd%0d_flow hs=%0d unst=%0d after=%0d to=%0d",
                    f, n_hs, unstable, done_after, timeout);
            end
            n_cmp++;
            if (got_max !== exp_max) begin
                n_bad++;
                $display("FAIL rnd%0d_max got=%h want=%h", f, got_max, exp_max);
            end
            for (int i = 0; i < N; i++) begin
                n_cmp++;
                if (got_res[i] !== exp_res[i]
                    || got_last[i] !== (i == N - 1)) begin
                    n_bad++;
                    $display("FAIL rnd%0d_out[%0d] got=%h/%b want=%h/%b", f, i,
                        got_res[i], got_last[i], exp_res[i], i == N - 1);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.in_valid_i = 1'b0;
        bus.in_data_i = '0;
        bus.out_ready_i = 1'b0;
        test_reset();
        test_alternating();
        test_backpressure();
        test_full_range();
        test_gaps_and_start();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
            n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/downscale_controller.md
Name: downscale_controller

Overview:
- Sequences the softmax downscale stage over one frame of NUMBER_OF_DATA signed samples.
- Pass 1 (LOAD): accepts the frame through a valid/ready handshake, stores it in an internal register buffer and tracks the running maximum.
- Pass 2 (EMIT): replays the buffer and presents (sample − max) to the downstream exponent stage, under backpressure.
- Sits between the input stream and the exp/normalise stages. Replaces free-running start_i streaming with a framed, flow-controlled interface.

Parameters:
- DATA_SIZE, 16: width of signed input samples.
- NUMBER_OF_DATA, 10: samples per frame and buffer depth; must be ≥2.

Ports:
- clock_i, input, 1: rising-edge clock. The block uses one clock only.
- reset_i, input, 1: synchronous, active-high reset.
- start_i, input, 1: one-cycle frame start; honoured only in IDLE.
- in_valid_i, input, 1: input sample valid.
- in_data_i, input, DATA_SIZE: signed input sample.
- in_ready_o, output, 1: block can accept a sample.
- out_valid_o, output, 1: sub_result_o valid.
- out_ready_i, input, 1: downstream accepts the result.
- sub_result_o, output, DATA_SIZE+1: signed sample − max.
- out_last_o, output, 1: the current output is the final sample of the frame.
- max_o, output, DATA_SIZE: frame maximum; valid from EMIT until the next start.
- busy_o, output, 1: high in LOAD or EMIT.
- done_o, output, 1: one-cycle pulse after the last output handshake.

Behaviour:
- Reset values, applied synchronously while reset_i=1 regardless of state:
  - State goes to IDLE.
  - Counters wr_idx and rd_idx = 0.
  - max_reg = most-negative DATA_SIZE value (0x8000 at default).
  - in_ready_o, out_valid_o, out_last_o, busy_o, done_o = 0.
  - sub_result_o = 0.
  - Buffer contents need not be reset.
  - Reset mid-frame discards the frame; no done_o pulse.
- IDLE:
  - All handshake outputs are low.
  - start_i=1 → LOAD on the next edge, with wr_idx=0 and max_reg re-initialised to the most-negative value.
- LOAD:
  - in_ready_o=1 (registered-state decode).
  - On in_valid_i & in_ready_o: buf[wr_idx]←in_data_i; max_reg←max(max_reg, in_data_i) using signed compare; wr_idx increments.
  - Handshake on wr_idx=NUMBER_OF_DATA−1 → EMIT next cycle, with rd_idx=0.
  - Gaps in in_valid_i only stall the load.
- EMIT:
  - out_valid_o=1.
  - sub_result_o = sext(buf[rd_idx]) − sext(max_reg), computed in DATA_SIZE+1 bits. It is combinational from registers, so there is zero latency from an index change.
  - Result is always ≤0 and ≥ −(2^DATA_SIZE − 1), so it never overflows.
  - out_last_o=1 when rd_idx=NUMBER_OF_DATA−1.
  - On out_valid_o & out_ready_i: rd_idx increments. On the last handshake → DONE.
  - With out_ready_i=0, all outputs hold stable.
- DONE:
  - done_o=1 for exactly one cycle, then IDLE.
  - max_o holds its value.
- Latency:
  - First out_valid_o is 1 cycle after the last input handshake.
  - Minimum frame time is 2·NUMBER_OF_DATA+2 cycles from start_i.
- Boundary conditions:
  - start_i outside IDLE is ignored, including during DONE.
  - in_valid_i outside LOAD is ignored (in_ready_o=0).
  - Equal samples: max is taken from the first occurrence; results are still computed, and the tie yields 0.
  - wr_idx and rd_idx never wrap inside a frame; both reset to 0 at the next frame.
  - A simultaneous reset_i and start_i: reset wins.

Optional Feature:
- Macro: DOWNSCALE_CTRL_CLAMP_EN.
- Defined: sub_result_o saturates at −2^(DATA_SIZE−1), i.e. 0x18000 as 17 bits at default, whenever the true difference is smaller. The output then always fits a DATA_SIZE signed value for a narrow exp LUT. Port width is unchanged.
- Undefined: full-precision DATA_SIZE+1 result, no clamp logic.

Test Plan:
- Alternating input: reset, start, 10 samples alternating 0xA440/0x2120 with in_valid continuous and out_ready=1.
  - Required: max_o=0x2120.
  - Outputs alternate 0x18320 (−31968) / 0x00000.
  - out_last_o set on the 10th output.
  - done_o pulses once, 22 cycles after start.
- Backpressure: same frame with out_ready_i toggling 1,0,0,1…
  - Required: each result is held stable while stalled, order is preserved, and exactly 10 handshakes occur.
- Full-range difference: frame with 0x8000 at index 3 and 0x7FFF elsewhere.
  - Required: index 3 output = 0x10001 (−65535) without the clamp macro; 0x18000 with DOWNSCALE_CTRL_CLAMP_EN. All other outputs = 0.
- Input gaps and ignored start: in_valid_i low for 3 cycles mid-load, plus start_i pulsed during LOAD and EMIT.
  - Required: load resumes correctly, the extra starts are ignored, and results match the gap-free run.
- Reset mid-frame: reset_i asserted after 5 samples are loaded.
  - Required: next cycle the block is in IDLE with all outputs 0 and no done_o.
  - A fresh all-0x0100 frame then yields max_o=0x0100 and ten 0 outputs.
